// File: rtl/spla_bist_pkg.sv
// rtl/spla_bist_pkg.sv - shared types, default polynomials and signature step for the spla BIST harness
package spla_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  localparam logic [15:0] DEF_SIG_POLY  = 16'h1021;
  localparam logic [15:0] DEF_LFSR_POLY = 16'hB400;

  // One serial signature shift: left shift, polynomial feedback from the msb, response into the lsb.
  function automatic logic [15:0] sig_step(input logic [15:0] sig,
                                           input logic        bit_in,
                                           input logic [15:0] poly);
    return {sig[14:0], 1'b0} ^ (sig[15] ? poly : 16'h0000) ^ {15'b0, bit_in};
  endfunction

endpackage

// File: rtl/spla_sig_reg.sv
// rtl/spla_sig_reg.sv - 16-bit serial signature register plus ones counter with clear and enable
module spla_sig_reg
  import spla_bist_pkg::*;
#(
  parameter int          ONES_W   = 17,
  parameter logic [15:0] SIG_POLY = DEF_SIG_POLY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              bit_in,
  output logic [15:0]       sig,
  output logic [ONES_W-1:0] ones
);

  // Clear wins over compaction so a new run always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig  <= '0;
      ones <= '0;
    end else if (clr) begin
      sig  <= '0;
      ones <= '0;
    end else if (en) begin
      sig  <= sig_step(sig, bit_in, SIG_POLY);
      ones <= ones + ONES_W'(bit_in);
    end
  end

endmodule

// File: rtl/spla_bist_harness.sv
// rtl/spla_bist_harness.sv - pattern source, run FSM and response compaction around the spla y0 cone
module spla_bist_harness
  import spla_bist_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               RESP_LAT  = 0,
  parameter logic [15:0]      SIG_POLY  = DEF_SIG_POLY,
  parameter logic [WIDTH-1:0] LFSR_POLY = WIDTH'(DEF_LFSR_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic [WIDTH:0]   n_pat_i,
  output logic [WIDTH-1:0] stim_o,
  input  logic             resp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      sig_o,
  output logic [WIDTH:0]   ones_o
);

  bist_state_e      state, state_n;
  logic             mode_q;
  logic [WIDTH:0]   rem;
  logic [1:0]       dcnt;
  logic             start_acc;
  logic             pat_valid;
  logic             comp_en;
  logic             last_pat;
  logic [WIDTH-1:0] seed_adj;
  logic [WIDTH-1:0] stim_next;

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  assign seed_adj  = (seed_i == '0) ? WIDTH'(1) : seed_i;
  assign stim_next = mode_q ? ((stim_o >> 1) ^ (stim_o[0] ? LFSR_POLY : '0))
                            : stim_o + WIDTH'(1);
  assign last_pat  = (rem == (WIDTH+1)'(1));
  // A pattern is on stim_o in every APPLY cycle; an aborting edge issues nothing.
  assign pat_valid = (state == ST_APPLY) && !abort_i;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state and status decode; abort overrides every other transition.
  always_comb begin
    state_n   = state;
    start_acc = 1'b0;
    busy_o    = (state == ST_APPLY) || (state == ST_DRAIN);
    done_o    = (state == ST_DONE);
    if (abort_i) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            start_acc = 1'b1;
            state_n   = (mode_i && n_pat_i == '0) ? ST_DONE : ST_APPLY;
          end
        end
        ST_APPLY: begin
          if (last_pat) state_n = (RESP_LAT == 0) ? ST_DONE : ST_DRAIN;
        end
        ST_DRAIN: begin
          if (dcnt == 2'd0) state_n = ST_DONE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Pattern source and remaining-pattern counter; the last pattern stays on stim_o after the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim_o <= '0;
      rem    <= '0;
      mode_q <= 1'b0;
    end else if (start_acc) begin
      mode_q <= mode_i;
      stim_o <= mode_i ? seed_adj : '0;
      rem    <= mode_i ? n_pat_i : {1'b1, {WIDTH{1'b0}}};
    end else if (pat_valid) begin
      rem <= rem - (WIDTH+1)'(1);
      if (!last_pat) stim_o <= stim_next;
    end
  end

  // Drain countdown, preloaded so that DRAIN lasts exactly RESP_LAT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             dcnt <= '0;
    else if (state == ST_DRAIN && !abort_i) dcnt <= dcnt - 2'd1;
    else                                    dcnt <= 2'(RESP_LAT - 1);
  end

  generate
    if (RESP_LAT == 0) begin : g_nolat
      assign comp_en = pat_valid;
    end else begin : g_lat
      logic [RESP_LAT-1:0] vline;
      // Valid bit follows each pattern through the cone's pipeline; abort discards in-flight responses.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vline <= '0;
        end else if (abort_i) begin
          vline <= '0;
        end else begin
          vline[0] <= pat_valid;
          for (int i = 1; i < RESP_LAT; i++) vline[i] <= vline[i-1];
        end
      end
      assign comp_en = vline[RESP_LAT-1] && !abort_i;
    end
  endgenerate

  spla_sig_reg #(
    .ONES_W   (WIDTH + 1),
    .SIG_POLY (SIG_POLY)
  ) u_sig (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_acc),
    .en     (comp_en),
    .bit_in (resp_i),
    .sig    (sig_o),
    .ones   (ones_o)
  );

endmodule

// File: tb/tb_spla_bist_harness.sv
// tb/tb_spla_bist_harness.sv - scoreboard bench for spla_bist_harness at RESP_LAT 0 and 2
module tb_spla_bist_harness;

  typedef struct {
    logic [15:0] sig;
    logic [16:0] ones;
    logic [15:0] last;
    int          cycles;
  } exp_t;

  logic        clk;
  logic        rst_n [2];
  logic        start [2];
  logic        abort [2];
  logic        mode  [2];
  logic [15:0] seed  [2];
  logic [16:0] npat  [2];
  logic [15:0] stim  [2];
  logic        busy  [2];
  logic        done  [2];
  logic [15:0] sig   [2];
  logic [16:0] ones  [2];
  logic        resp0, resp1;
  logic [15:0] p1, p2;
  int          src [2];

  int n_tests = 0;
  int n_fail  = 0;

  exp_t        sb0 [$];
  exp_t        sb1 [$];
  logic [15:0] pq0 [$];
  logic [15:0] pq1 [$];

  spla_bist_harness #(.RESP_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .start_i(start[0]), .abort_i(abort[0]),
    .mode_i(mode[0]), .seed_i(seed[0]), .n_pat_i(npat[0]), .stim_o(stim[0]),
    .resp_i(resp0), .busy_o(busy[0]), .done_o(done[0]), .sig_o(sig[0]), .ones_o(ones[0])
  );

  spla_bist_harness #(.RESP_LAT(2)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .start_i(start[1]), .abort_i(abort[1]),
    .mode_i(mode[1]), .seed_i(seed[1]), .n_pat_i(npat[1]), .stim_o(stim[1]),
    .resp_i(resp1), .busy_o(busy[1]), .done_o(done[1]), .sig_o(sig[1]), .ones_o(ones[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the y0 cone: x0 = 1 forces y0 = 1.
  function automatic logic cone(input logic [15:0] x);
    return x[0] | (x[7] & ~x[3]) | (x[15] ^ x[11] ^ x[2]);
  endfunction

  function automatic logic rfn(input int s, input logic [15:0] x);
    case (s)
      0:       return x[0];
      1:       return 1'b0;
      default: return cone(x);
    endcase
  endfunction

  function automatic logic [15:0] lfsr(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] sstep(input logic [15:0] s, input logic r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, r};
  endfunction

  always_comb resp0 = rfn(src[0], stim[0]);

  // Two register stages model a pipelined cone for the RESP_LAT = 2 instance.
  always @(posedge clk) begin
    p1 <= stim[1];
    p2 <= p1;
  end
  always_comb resp1 = rfn(src[1], p2);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input int d, input bit m, input logic [15:0] sd, input logic [16:0] n,
                     input int s, input bit poke, input string tag);
    exp_t        e;
    logic [15:0] p;
    logic [15:0] ep;
    logic        r;
    int          nn;
    int          c;
    int          lat;
    lat    = (d == 0) ? 0 : 2;
    p      = m ? ((sd == 16'h0) ? 16'h0001 : sd) : 16'h0000;
    nn     = m ? int'(n) : 65536;
    e.sig  = '0;
    e.ones = '0;
    e.last = p;
    for (int k = 0; k < nn; k++) begin
      if (nn <= 64) begin
        if (d == 0) pq0.push_back(p);
        else        pq1.push_back(p);
      end
      r      = rfn(s, p);
      e.sig  = sstep(e.sig, r);
      e.ones = e.ones + 17'(r);
      e.last = p;
      if (k != nn - 1) p = m ? lfsr(p) : p + 16'd1;
    end
    e.cycles = (nn == 0) ? 0 : nn + lat;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);

    src[d]  = s;
    mode[d] = m;
    seed[d] = sd;
    npat[d] = n;
    @(negedge clk) start[d] = 1'b1;
    @(negedge clk) start[d] = 1'b0;
    c = 0;
    if (nn > 0) chk({tag, "_busy_rise"}, busy[d], 1'b1);
    while (!done[d] && c < 70000) begin
      if (c < nn && ((d == 0) ? pq0.size() : pq1.size()) > 0) begin
        ep = (d == 0) ? pq0.pop_front() : pq1.pop_front();
        chk({tag, "_stim"}, stim[d], ep);
      end
      start[d] = poke && (c == 10 || c == nn || c == nn + 1);
      @(negedge clk);
      c++;
    end
    start[d] = 1'b0;
    if (d == 0) pq0.delete();
    else        pq1.delete();

    e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
    chk({tag, "_cycles"}, c, e.cycles);
    chk({tag, "_sig"}, sig[d], e.sig);
    chk({tag, "_ones"}, ones[d], e.ones);
    chk({tag, "_last_stim"}, stim[d], e.last);
    chk({tag, "_busy_done"}, busy[d], 1'b0);
    @(negedge clk);
    chk({tag, "_done_hold"}, done[d], 1'b1);
    chk({tag, "_sig_hold"}, sig[d], e.sig);
  endtask

  task automatic run_abort();
    logic [15:0] p;
    logic [15:0] s;
    logic [16:0] o;
    logic        r;
    logic        seen;
    int          c;
    p = 16'hACE1;
    s = '0;
    o = '0;
    for (int k = 0; k < 99; k++) begin
      r = cone(p);
      s = sstep(s, r);
      o = o + 17'(r);
      p = lfsr(p);
    end
    src[0]  = 2;
    mode[0] = 1'b1;
    seed[0] = 16'hACE1;
    npat[0] = 17'd300;
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    c = 0;
    while (c < 99) begin
      @(negedge clk);
      c++;
    end
    abort[0] = 1'b1;
    @(negedge clk) abort[0] = 1'b0;
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_done", done[0], 1'b0);
    chk("abort_stim_kept", stim[0], p);
    chk("abort_sig_partial", sig[0], s);
    chk("abort_ones_partial", ones[0], o);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done[0]) seen = 1'b1;
    end
    chk("abort_no_done", seen, 1'b0);
  endtask

  task automatic run_reset_drain();
    int c;
    src[1]  = 2;
    mode[1] = 1'b1;
    seed[1] = 16'h0F0F;
    npat[1] = 17'd20;
    @(negedge clk) start[1] = 1'b1;
    @(negedge clk) start[1] = 1'b0;
    c = 0;
    while (c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("drain_busy", busy[1], 1'b1);
    rst_n[1] = 1'b0;
    #1;
    chk("rst_mid_stim", stim[1], 16'h0);
    chk("rst_mid_busy", busy[1], 1'b0);
    chk("rst_mid_done", done[1], 1'b0);
    chk("rst_mid_sig", sig[1], 16'h0);
    chk("rst_mid_ones", ones[1], 17'h0);
    @(negedge clk) rst_n[1] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0;
      start[i] = 1'b0;
      abort[i] = 1'b0;
      mode[i]  = 1'b0;
      seed[i]  = '0;
      npat[i]  = '0;
      src[i]   = 1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_stim", stim[i], 16'h0);
      chk("rst_busy", busy[i], 1'b0);
      chk("rst_done", done[i], 1'b0);
      chk("rst_sig", sig[i], 16'h0);
      chk("rst_ones", ones[i], 17'h0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);

    run(0, 1'b1, 16'h0000, 17'd5, 0, 1'b0, "lfsr_seed0");
    run(0, 1'b1, 16'h0001, 17'd1, 2, 1'b0, "cone_x0");
    chk("cone_x0_ones_one", ones[0], 17'd1);
    run(0, 1'b1, 16'h1234, 17'd0, 2, 1'b0, "npat_zero");

    @(negedge clk) begin
      start[0] = 1'b1;
      abort[0] = 1'b1;
    end
    @(negedge clk) begin
      start[0] = 1'b0;
      abort[0] = 1'b0;
    end
    chk("start_abort_busy", busy[0], 1'b0);
    chk("start_abort_done", done[0], 1'b0);

    run_abort();
    run(0, 1'b1, 16'hACE1, 17'd300, 2, 1'b0, "restart");

    run(1, 1'b1, 16'h1234, 17'd40, 2, 1'b1, "lat2_poke");
    run_reset_drain();

    fork
      run(0, 1'b0, 16'h0000, 17'd0, 0, 1'b0, "cnt_x0");
      run(1, 1'b0, 16'h0000, 17'd0, 1, 1'b0, "cnt_zero");
    join
    chk("cnt_x0_half", ones[0], 17'd32768);
    chk("cnt_zero_last", stim[1], 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
